// File: rtl/complex_wb_stage.sv
// complex_wb_stage: fixed-latency writeback pipeline feeding a credit-guarded FIFO.
// Optional residue error tracking is enabled with RESIDUE_CHECK_EN.
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif
`ifndef EXECUTION_FLAGS
`define EXECUTION_FLAGS 6
`endif
`ifndef SIZE_PHYSICAL_LOG
`define SIZE_PHYSICAL_LOG 7
`endif

module complex_wb_stage #(
  parameter int LATENCY = 3,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          valid_i,
  input  logic [2*`SIZE_DATA-1:0]       result_i,
  input  logic [`EXECUTION_FLAGS-1:0]   flags_i,
  input  logic                          error_i,
  input  logic [`SIZE_PHYSICAL_LOG-1:0] tag_i,
  input  logic                          flush_i,
  input  logic                          wb_ready_i,
  output logic                          stall_o,
  output logic                          wb_valid_o,
  output logic [`SIZE_DATA-1:0]         wb_data_o,
  output logic [`SIZE_PHYSICAL_LOG-1:0] wb_tag_o,
  output logic [`EXECUTION_FLAGS-1:0]   wb_flags_o,
  output logic                          overflow_o,
  output logic                          err_sticky_o,
  output logic [7:0]                    err_count_o
);
  localparam int AW = $clog2(DEPTH);
  typedef struct packed {
    logic [`SIZE_DATA-1:0]         data;
    logic [`SIZE_PHYSICAL_LOG-1:0] tag;
    logic [`EXECUTION_FLAGS-1:0]   flags;
`ifdef RESIDUE_CHECK_EN
    logic                          err;
`endif
  } entry_t;
  logic [LATENCY-1:0] pv_q, pv_d;
  entry_t pe_q [LATENCY];
  entry_t pe_d [LATENCY];
  entry_t mem_q [DEPTH];
  entry_t mem_d [DEPTH];
  entry_t in_e, head;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0] cnt_q, cnt_d, credit_q, credit_d;
  logic overflow_q, overflow_d;
  logic accept, push, pop;
  logic unused_ok;
  assign unused_ok = ^{result_i[2*`SIZE_DATA-1:`SIZE_DATA], error_i};
  assign stall_o = credit_q >= (AW+1)'(DEPTH);
  assign wb_valid_o = cnt_q != '0;
  assign head = mem_q[rd_q];
  assign wb_data_o = wb_valid_o ? head.data : '0;
  assign wb_tag_o = wb_valid_o ? head.tag : '0;
  assign wb_flags_o = wb_valid_o ? head.flags : '0;
  assign overflow_o = overflow_q;
  assign accept = valid_i & ~stall_o & ~flush_i;
  assign push = pv_q[LATENCY-1] & ~flush_i;
  assign pop = wb_valid_o & wb_ready_i & ~flush_i;
  always_comb begin
    in_e.data = result_i[`SIZE_DATA-1:0];
    in_e.tag = tag_i;
`ifdef RESIDUE_CHECK_EN
    // Exception flag is folded in at capture so the FIFO holds final flags.
    in_e.flags = flags_i | {{(`EXECUTION_FLAGS-2){1'b0}}, error_i, 1'b0};
    in_e.err = error_i;
`else
    in_e.flags = flags_i;
`endif
    pv_d[0] = accept;
    pe_d[0] = in_e;
    for (int i = 1; i < LATENCY; i++) begin
      pv_d[i] = pv_q[i-1];
      pe_d[i] = pe_q[i-1];
    end
    if (flush_i) pv_d = '0;
    mem_d = mem_q;
    if (push) mem_d[wr_q] = pe_q[LATENCY-1];
    wr_d = flush_i ? '0 : wr_q + AW'(push);
    rd_d = flush_i ? '0 : rd_q + AW'(pop);
    cnt_d = flush_i ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    credit_d = flush_i ? '0 : credit_q + (AW+1)'(accept) - (AW+1)'(pop);
    overflow_d = valid_i & stall_o;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pv_q <= '0;
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
      credit_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      pv_q <= pv_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
      credit_q <= credit_d;
      overflow_q <= overflow_d;
    end
  end
  always_ff @(posedge clk) begin
    pe_q <= pe_d;
    mem_q <= mem_d;
  end
`ifdef RESIDUE_CHECK_EN
  logic err_q, err_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic push_err;
  assign push_err = push & pe_q[LATENCY-1].err;
  assign err_d = err_q | push_err;
  assign err_cnt_d = (push_err && err_cnt_q != 8'hff) ? err_cnt_q + 8'd1 : err_cnt_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_q <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end
  assign err_sticky_o = err_q;
  assign err_count_o = err_cnt_q;
`else
  assign err_sticky_o = 1'b0;
  assign err_count_o = '0;
`endif
endmodule

// File: tb/tb_complex_wb_stage.sv
// tb_complex_wb_stage: directed self-checking bench for complex_wb_stage (LATENCY=3, DEPTH=4).
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif
`ifndef EXECUTION_FLAGS
`define EXECUTION_FLAGS 6
`endif
`ifndef SIZE_PHYSICAL_LOG
`define SIZE_PHYSICAL_LOG 7
`endif

module tb_complex_wb_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic valid_i = 1'b0;
  logic [2*`SIZE_DATA-1:0] result_i = '0;
  logic [`EXECUTION_FLAGS-1:0] flags_i = '0;
  logic error_i = 1'b0;
  logic [`SIZE_PHYSICAL_LOG-1:0] tag_i = '0;
  logic flush_i = 1'b0;
  logic wb_ready_i = 1'b0;
  logic stall_o, wb_valid_o, overflow_o, err_sticky_o;
  logic [`SIZE_DATA-1:0] wb_data_o;
  logic [`SIZE_PHYSICAL_LOG-1:0] wb_tag_o;
  logic [`EXECUTION_FLAGS-1:0] wb_flags_o;
  logic [7:0] err_count_o;
  int checks = 0;
  int errors = 0;

  complex_wb_stage #(.LATENCY(3), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .result_i(result_i),
    .flags_i(flags_i), .error_i(error_i), .tag_i(tag_i), .flush_i(flush_i),
    .wb_ready_i(wb_ready_i), .stall_o(stall_o), .wb_valid_o(wb_valid_o),
    .wb_data_o(wb_data_o), .wb_tag_o(wb_tag_o), .wb_flags_o(wb_flags_o),
    .overflow_o(overflow_o), .err_sticky_o(err_sticky_o), .err_count_o(err_count_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  initial begin
    step();
    step();
    reset = 1'b0;
    chk("rst_wb_valid", 64'(wb_valid_o), 64'd0);
    chk("rst_stall", 64'(stall_o), 64'd0);
    chk("rst_overflow", 64'(overflow_o), 64'd0);
    chk("rst_err_sticky", 64'(err_sticky_o), 64'd0);
    chk("rst_err_count", 64'(err_count_o), 64'd0);
    chk("rst_wb_data", 64'(wb_data_o), 64'd0);
    // Single entry latency
    wb_ready_i = 1'b1;
    valid_i = 1'b1;
    result_i = 64'h0000_0001_0000_0005;
    tag_i = 7;
    flags_i = 6'b000101;
    step();
    valid_i = 1'b0;
    chk("lat_n0", 64'(wb_valid_o), 64'd0);
    step();
    chk("lat_n1", 64'(wb_valid_o), 64'd0);
    step();
    chk("lat_n2", 64'(wb_valid_o), 64'd0);
    step();
    chk("lat_n3_valid", 64'(wb_valid_o), 64'd1);
    chk("lat_n3_data", 64'(wb_data_o), 64'h5);
    chk("lat_n3_tag", 64'(wb_tag_o), 64'd7);
    chk("lat_n3_flags", 64'(wb_flags_o), 64'b000101);
    step();
    chk("lat_n4_valid", 64'(wb_valid_o), 64'd0);
    chk("lat_n4_data", 64'(wb_data_o), 64'd0);
    chk("lat_n4_tag", 64'(wb_tag_o), 64'd0);
    // Fill to stall with consumer blocked
    wb_ready_i = 1'b0;
    valid_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tag_i = 7'(i);
      result_i = 64'(i * 16);
      chk("fill_stall_pre", 64'(stall_o), 64'd0);
      step();
    end
    chk("fill_stall", 64'(stall_o), 64'd1);
    chk("fill_no_ovf", 64'(overflow_o), 64'd0);
    tag_i = 5;
    step();
    valid_i = 1'b0;
    chk("ovf_pulse", 64'(overflow_o), 64'd1);
    step();
    chk("ovf_clear", 64'(overflow_o), 64'd0);
    step();
    step();
    chk("full_valid", 64'(wb_valid_o), 64'd1);
    chk("full_tag1", 64'(wb_tag_o), 64'd1);
    chk("full_data1", 64'(wb_data_o), 64'h10);
    step();
    chk("hold_tag1", 64'(wb_tag_o), 64'd1);
    chk("hold_stall", 64'(stall_o), 64'd1);
    // Pop one, refill, then simultaneous push and pop
    wb_ready_i = 1'b1;
    step();
    wb_ready_i = 1'b0;
    chk("pop_tag2", 64'(wb_tag_o), 64'd2);
    chk("pop_unstall", 64'(stall_o), 64'd0);
    valid_i = 1'b1;
    tag_i = 6;
    result_i = 64'h60;
    step();
    valid_i = 1'b0;
    chk("refill_stall", 64'(stall_o), 64'd1);
    step();
    step();
    chk("refill_hold_tag2", 64'(wb_tag_o), 64'd2);
    wb_ready_i = 1'b1;
    step();
    chk("pushpop_tag3", 64'(wb_tag_o), 64'd3);
    chk("pushpop_stall", 64'(stall_o), 64'd0);
    step();
    chk("drain_tag4", 64'(wb_tag_o), 64'd4);
    step();
    chk("drain_tag6", 64'(wb_tag_o), 64'd6);
    chk("drain_data6", 64'(wb_data_o), 64'h60);
    step();
    chk("drain_empty", 64'(wb_valid_o), 64'd0);
    // Flush with buffered and in-flight entries plus a new valid
    wb_ready_i = 1'b0;
    valid_i = 1'b1;
    for (int i = 10; i <= 12; i++) begin
      tag_i = 7'(i);
      step();
    end
    valid_i = 1'b0;
    step();
    step();
    chk("preflush_tag10", 64'(wb_tag_o), 64'd10);
    chk("preflush_stall", 64'(stall_o), 64'd0);
    flush_i = 1'b1;
    valid_i = 1'b1;
    tag_i = 14;
    step();
    flush_i = 1'b0;
    valid_i = 1'b0;
    chk("flush_wb_valid", 64'(wb_valid_o), 64'd0);
    chk("flush_stall", 64'(stall_o), 64'd0);
    chk("flush_no_ovf", 64'(overflow_o), 64'd0);
    for (int i = 0; i < 5; i++) step();
    chk("flush_nothing_later", 64'(wb_valid_o), 64'd0);
    // Residue error entry
    wb_ready_i = 1'b1;
    valid_i = 1'b1;
    error_i = 1'b1;
    flags_i = 6'b011100;
    tag_i = 3;
    result_i = 64'h0000_0000_0000_abcd;
    step();
    valid_i = 1'b0;
    error_i = 1'b0;
    step();
    step();
    step();
    chk("err_valid", 64'(wb_valid_o), 64'd1);
    chk("err_data", 64'(wb_data_o), 64'habcd);
`ifdef RESIDUE_CHECK_EN
    chk("err_flags", 64'(wb_flags_o), 64'b011110);
    chk("err_sticky", 64'(err_sticky_o), 64'd1);
    chk("err_count", 64'(err_count_o), 64'd1);
`else
    chk("err_flags", 64'(wb_flags_o), 64'b011100);
    chk("err_sticky", 64'(err_sticky_o), 64'd0);
    chk("err_count", 64'(err_count_o), 64'd0);
`endif
    step();
    // Reset with buffered entries
    wb_ready_i = 1'b0;
    valid_i = 1'b1;
    tag_i = 20;
    step();
    tag_i = 21;
    step();
    valid_i = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("prereset_tag20", 64'(wb_tag_o), 64'd20);
    reset = 1'b1;
    step();
    chk("mrst_wb_valid", 64'(wb_valid_o), 64'd0);
    chk("mrst_stall", 64'(stall_o), 64'd0);
    chk("mrst_overflow", 64'(overflow_o), 64'd0);
    chk("mrst_err_sticky", 64'(err_sticky_o), 64'd0);
    chk("mrst_err_count", 64'(err_count_o), 64'd0);
    chk("mrst_wb_tag", 64'(wb_tag_o), 64'd0);
    chk("mrst_wb_data", 64'(wb_data_o), 64'd0);
    // First accept on the edge right after reset deasserts
    reset = 1'b0;
    wb_ready_i = 1'b1;
    valid_i = 1'b1;
    tag_i = 9;
    result_i = 64'h99;
    step();
    valid_i = 1'b0;
    step();
    step();
    chk("post_rst_n2", 64'(wb_valid_o), 64'd0);
    step();
    chk("post_rst_valid", 64'(wb_valid_o), 64'd1);
    chk("post_rst_tag9", 64'(wb_tag_o), 64'd9);
    step();
    chk("post_rst_one_cycle", 64'(wb_valid_o), 64'd0);
    step();
    chk("post_rst_no_old", 64'(wb_valid_o), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
